// File: rtl/io_timer_irq.sv
// IO-store-mapped timer: prescaled 32-bit up-counter with compare match, sticky pending flag and level IRQ.
// Optional `IO_TIMER_AUTO_RELOAD_EN: counter returns to 0 on a match tick (periodic interrupt).
module io_timer_irq #(
   parameter int PRESC_W = 8,
   parameter int LED_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [11:2]      st_adr_io,
   input  logic [31:0]      st_data_io,
   input  logic [3:0]       st_we_io,
   output logic             interrupt_0,
   output logic [LED_W-1:0] led,
   output logic [31:0]      timer_count
);

   localparam logic [9:0] ADR_CTRL    = 10'h000;
   localparam logic [9:0] ADR_COMPARE = 10'h001;
   localparam logic [9:0] ADR_STATUS  = 10'h002;
   localparam logic [9:0] ADR_COUNT   = 10'h003;
   localparam logic [9:0] ADR_LED     = 10'h004;

   logic               en_q, en_d;
   logic               irq_en_q, irq_en_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic [31:0]        compare_q, compare_d;
   logic [31:0]        count_q, count_d;
   logic               pending_q, pending_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic               irq_q, irq_d;

   logic        wr, sel_ctrl, sel_compare, sel_status, sel_count, sel_led;
   logic        tick, match, w1c;
   logic [31:0] ctrl_old, ctrl_new, led_old, led_new, compare_new, count_new;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = we[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   assign wr          = |st_we_io;
   assign sel_ctrl    = wr && (st_adr_io == ADR_CTRL);
   assign sel_compare = wr && (st_adr_io == ADR_COMPARE);
   assign sel_status  = wr && (st_adr_io == ADR_STATUS);
   assign sel_count   = wr && (st_adr_io == ADR_COUNT);
   assign sel_led     = wr && (st_adr_io == ADR_LED);

   // Registers are packed into their 32-bit bus images so byte enables merge uniformly.
   always_comb begin
      ctrl_old                  = '0;
      ctrl_old[0]               = en_q;
      ctrl_old[1]               = irq_en_q;
      ctrl_old[8 +: PRESC_W]    = presc_q;
      led_old                   = '0;
      led_old[LED_W-1:0]        = led_q;
      ctrl_new    = merge_bytes(ctrl_old, st_data_io, st_we_io);
      led_new     = merge_bytes(led_old, st_data_io, st_we_io);
      compare_new = merge_bytes(compare_q, st_data_io, st_we_io);
      count_new   = merge_bytes(count_q, st_data_io, st_we_io);
   end

   assign tick  = en_q && (presc_cnt_q == presc_q);
   assign match = tick && (count_q == compare_q);
   assign w1c   = sel_status && st_we_io[0] && st_data_io[0];

   always_comb begin
      en_d        = en_q;
      irq_en_d    = irq_en_q;
      presc_d     = presc_q;
      compare_d   = compare_q;
      led_d       = led_q;
      presc_cnt_d = presc_cnt_q;
      count_d     = count_q;
      pending_d   = pending_q;
      irq_d       = pending_q & irq_en_q;

      if (sel_ctrl) begin
         en_d     = ctrl_new[0];
         irq_en_d = ctrl_new[1];
         presc_d  = ctrl_new[8 +: PRESC_W];
      end
      if (sel_compare) compare_d = compare_new;
      if (sel_led)     led_d     = led_new[LED_W-1:0];

      if (en_q) begin
         presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
      end

      if (tick) begin
`ifdef IO_TIMER_AUTO_RELOAD_EN
         count_d = match ? 32'd0 : count_q + 32'd1;
`else
         count_d = count_q + 32'd1;
`endif
      end

      // A COUNT store overrides this cycle's tick and restarts the prescale period.
      if (sel_count) begin
         count_d     = count_new;
         presc_cnt_d = '0;
      end

      if (match)    pending_d = 1'b1;
      else if (w1c) pending_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         presc_q     <= '0;
         presc_cnt_q <= '0;
         compare_q   <= '0;
         count_q     <= '0;
         pending_q   <= 1'b0;
         led_q       <= '0;
         irq_q       <= 1'b0;
      end else begin
         en_q        <= en_d;
         irq_en_q    <= irq_en_d;
         presc_q     <= presc_d;
         presc_cnt_q <= presc_cnt_d;
         compare_q   <= compare_d;
         count_q     <= count_d;
         pending_q   <= pending_d;
         led_q       <= led_d;
         irq_q       <= irq_d;
      end
   end

   assign interrupt_0 = irq_q;
   assign led         = led_q;
   assign timer_count = count_q;

endmodule

// File: tb/tb_io_timer_irq.sv
// Directed bench for io_timer_irq; inputs driven and outputs sampled on the falling edge.
// Expectations follow `IO_TIMER_AUTO_RELOAD_EN the same way the design does.
module tb_io_timer_irq;

   logic        clk;
   logic        rst;
   logic [11:2] st_adr_io;
   logic [31:0] st_data_io;
   logic [3:0]  st_we_io;
   logic        interrupt_0;
   logic [2:0]  led;
   logic [31:0] timer_count;

   int n_cmp = 0;
   int n_err = 0;

   io_timer_irq #(.PRESC_W(8), .LED_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .st_adr_io   (st_adr_io),
      .st_data_io  (st_data_io),
      .st_we_io    (st_we_io),
      .interrupt_0 (interrupt_0),
      .led         (led),
      .timer_count (timer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Presents one store for a single cycle; returns at the falling edge after the store edge.
   task automatic store(input logic [9:0] adr, input logic [31:0] data, input logic [3:0] we);
      st_adr_io  = adr;
      st_data_io = data;
      st_we_io   = we;
      @(negedge clk);
      st_we_io   = 4'h0;
   endtask

   initial begin
      int hi;
      rst        = 1'b1;
      st_adr_io  = 10'h000;
      st_data_io = 32'h0;
      st_we_io   = 4'h0;
      cyc(2);
      rst = 1'b0;
      chk("rst_irq", 32'(interrupt_0), 32'd0);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_count", timer_count, 32'd0);
      cyc(5);
      chk("no_tick_without_en", timer_count, 32'd0);

      store(10'h003, 32'hAABBCCDD, 4'b0101);
      chk("count_byte_we", timer_count, 32'h00BB00DD);
      store(10'h3FF, 32'hFFFFFFFF, 4'hF);
      chk("unmapped_count", timer_count, 32'h00BB00DD);
      chk("unmapped_led", 32'(led), 32'd0);
      store(10'h004, 32'hFFFFFFFF, 4'b0001);
      chk("led_write", 32'(led), 32'd7);
      store(10'h004, 32'h00000000, 4'b1110);
      chk("led_upper_bytes", 32'(led), 32'd7);

      store(10'h001, 32'd3, 4'hF);
      store(10'h003, 32'd0, 4'hF);
      store(10'h000, 32'h3, 4'hF);
      chk("basic_e0", timer_count, 32'd0);
      cyc(3);
      chk("basic_e3_count", timer_count, 32'd3);
      chk("basic_e3_irq", 32'(interrupt_0), 32'd0);
      cyc(1);
`ifdef IO_TIMER_AUTO_RELOAD_EN
      chk("basic_e4_count", timer_count, 32'd0);
`else
      chk("basic_e4_count", timer_count, 32'd4);
`endif
      chk("basic_e4_irq", 32'(interrupt_0), 32'd0);
      cyc(1);
      chk("basic_e5_irq", 32'(interrupt_0), 32'd1);
      store(10'h000, 32'h2, 4'hF);
      cyc(3);
      chk("pending_holds", 32'(interrupt_0), 32'd1);
      store(10'h002, 32'h1, 4'b0001);
      chk("w1c_edge_irq", 32'(interrupt_0), 32'd1);
      cyc(1);
      chk("w1c_next_irq", 32'(interrupt_0), 32'd0);

      store(10'h001, 32'd5, 4'hF);
      store(10'h003, 32'hFFFFFFFE, 4'hF);
      store(10'h000, 32'h203, 4'hF);
      cyc(2);
      chk("presc_e2", timer_count, 32'hFFFFFFFE);
      cyc(1);
      chk("presc_e3", timer_count, 32'hFFFFFFFF);
      cyc(2);
      chk("presc_e5", timer_count, 32'hFFFFFFFF);
      cyc(1);
      chk("presc_wrap_e6", timer_count, 32'h0);
      chk("presc_no_irq", 32'(interrupt_0), 32'd0);
      store(10'h000, 32'h202, 4'hF);
      cyc(5);
      chk("freeze_count", timer_count, 32'h0);
      store(10'h000, 32'h203, 4'hF);
      chk("resume_r0", timer_count, 32'h0);
      cyc(1);
      chk("resume_r1", timer_count, 32'h0);
      cyc(1);
      chk("resume_r2", timer_count, 32'h1);

      store(10'h000, 32'h0, 4'hF);
      store(10'h001, 32'd2, 4'hF);
      store(10'h003, 32'd0, 4'hF);
      store(10'h000, 32'h3, 4'hF);
      cyc(2);
      chk("coll_count", timer_count, 32'd2);
      store(10'h002, 32'h1, 4'b0001);
      chk("coll_irq_edge", 32'(interrupt_0), 32'd0);
      cyc(1);
      chk("w1c_vs_match", 32'(interrupt_0), 32'd1);
      store(10'h003, 32'h100, 4'hF);
      chk("count_wr_vs_tick", timer_count, 32'h100);
      cyc(1);
      chk("count_after_wr", timer_count, 32'h101);
      store(10'h000, 32'h0, 4'hF);
      chk("irq_en_clr_edge", 32'(interrupt_0), 32'd1);
      cyc(1);
      chk("irq_en_clr_next", 32'(interrupt_0), 32'd0);
      store(10'h002, 32'h1, 4'b0001);

      store(10'h003, 32'd0, 4'hF);
      store(10'h000, 32'h3, 4'hF);
      cyc(3);
      chk("reload_e3_irq", 32'(interrupt_0), 32'd0);
      cyc(1);
      chk("reload_e4_irq", 32'(interrupt_0), 32'd1);
      store(10'h002, 32'h1, 4'b0001);
      chk("reload_e5_irq", 32'(interrupt_0), 32'd1);
      cyc(1);
      chk("reload_e6_irq", 32'(interrupt_0), 32'd0);
      cyc(1);
`ifdef IO_TIMER_AUTO_RELOAD_EN
      chk("reload_e7_irq", 32'(interrupt_0), 32'd1);
      store(10'h002, 32'h1, 4'b0001);
      chk("reload_e8_irq", 32'(interrupt_0), 32'd1);
      cyc(1);
      chk("reload_e9_irq", 32'(interrupt_0), 32'd0);
      cyc(1);
      chk("reload_e10_irq", 32'(interrupt_0), 32'd1);
`else
      chk("noreload_e7_irq", 32'(interrupt_0), 32'd0);
      hi = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (interrupt_0) hi++;
      end
      chk("no_second_match", 32'(hi), 32'd0);
`endif

      st_adr_io  = 10'h004;
      st_data_io = 32'h5;
      st_we_io   = 4'hF;
      rst        = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      st_we_io = 4'h0;
      chk("midrst_led", 32'(led), 32'd0);
      chk("midrst_count", timer_count, 32'd0);
      chk("midrst_irq", 32'(interrupt_0), 32'd0);
      cyc(3);
      chk("midrst_idle", timer_count, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
